uart_frame_parser: RTL and testbench

Downstream consumer of the UART receiver's byte stream. Hunts for a sync byte, captures a length-prefixed payload into an internal buffer, verifies an 8-bit additive checksum, then releases the payload on a valid/ready byte stream. Corrupt, oversized or stalled frames are discarded and flagged. Sits between the UART receiver and the command decoder.

---
 rtl/uart_frame_parser.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: sync hunt, length-prefixed payload capture,
// additive checksum check, then valid/ready release of the buffered payload.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 8700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic       o_frame_ok,
    output logic       o_err_chk,
    output logic       o_err_len,
    output logic       o_err_timeout,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned IW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]    LEN_MAX_B = 8'(MAX_LEN);
    // Counter lags the strobe by one cycle and the pulse is registered, so firing at
    // this value lands o_err_timeout TIMEOUT_CLKS-1 cycles after the last strobe.
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    acc_q, acc_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    buf_q [MAX_LEN];
    logic          wr_en;

    logic [7:0] data_d;
    logic       valid_d, last_d, busy_d;
    logic       ok_d, chk_d, elen_d, eto_d, ovr_d;

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        to_d    = to_q;
        wr_en   = 1'b0;
        ok_d    = 1'b0;
        chk_d   = 1'b0;
        elen_d  = 1'b0;
        eto_d   = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != 8'd0 && i_Rx_Byte <= LEN_MAX_B) begin
                        len_d   = IW'(i_Rx_Byte);
                        acc_d   = i_Rx_Byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        elen_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en = 1'b1;
                    acc_d = acc_q + i_Rx_Byte;
                    idx_d = idx_q + IW'(1);
                    if (idx_d == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == acc_q) begin
                        ok_d    = 1'b1;
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        chk_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                ovr_d = i_Rx_DV;
                if (i_ready) begin
                    if (idx_q == len_q - IW'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout only while a frame is being received
        if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) begin
            if (i_Rx_DV) begin
                to_d = '0;
            end else if (to_q == TO_LAST) begin
                eto_d   = 1'b1;
                to_d    = '0;
                state_d = S_IDLE;
            end else begin
                to_d = to_q + TW'(1);
            end
        end else begin
            to_d = '0;
        end

        valid_d = (state_d == S_DRAIN);
        last_d  = valid_d && (idx_d == len_d - IW'(1));
        data_d  = valid_d ? buf_q[idx_d[AW-1:0]] : 8'd0;
        busy_d  = (state_d != S_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            to_q          <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_last        <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_err_chk     <= 1'b0;
            o_err_len     <= 1'b0;
            o_err_timeout <= 1'b0;
            o_overrun     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            to_q          <= to_d;
            o_data        <= data_d;
            o_valid       <= valid_d;
            o_last        <= last_d;
            o_frame_ok    <= ok_d;
            o_err_chk     <= chk_d;
            o_err_len     <= elen_d;
            o_err_timeout <= eto_d;
            o_overrun     <= ovr_d;
            o_busy        <= busy_d;
        end
    end

    // Payload buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[idx_q[AW-1:0]] <= i_Rx_Byte;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed timing sequences, a vector
// table of frame shapes, and randomized frames against a frame-level model.
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TIMEOUT = 8700;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_last, o_frame_ok, o_err_chk, o_err_len;
    logic       o_err_timeout, o_overrun, o_busy;

    always #5 clk = ~clk;

    uart_frame_parser dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_last       (o_last),
        .o_frame_ok   (o_frame_ok),
        .o_err_chk    (o_err_chk),
        .o_err_len    (o_err_len),
        .o_err_timeout(o_err_timeout),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Event and handshake monitor, sampled on the falling edge
    int n_ok = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0, n_valid = 0;
    logic [7:0] got_data[$];
    logic       got_last[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_frame_ok)    n_ok++;
            if (o_err_chk)     n_chk++;
            if (o_err_len)     n_len++;
            if (o_err_timeout) n_to++;
            if (o_overrun)     n_ovr++;
            if (o_valid)       n_valid++;
            if (o_valid && ready) begin
                got_data.push_back(o_data);
                got_last.push_back(o_last);
            end
        end
    end

    int s_ok, s_chk, s_len, s_to, s_ovr, s_valid, s_got;
    logic [7:0] txq[$];

    typedef struct {
        logic [7:0] len;
        logic [7:0] chk_add;
        int         ok;
        int         bad_chk;
        int         bad_len;
        int         nbytes;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        s_ok = n_ok; s_chk = n_chk; s_len = n_len; s_to = n_to;
        s_ovr = n_ovr; s_valid = n_valid; s_got = got_data.size();
    endtask

    // All drive tasks start and end 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic send_txq(input int gapmax);
        foreach (txq[i]) begin
            strobe(txq[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
        txq.delete();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && o_busy; i++) tick();
        check("drain_done", o_busy, 0);
    endtask

    function automatic logic [7:0] pbyte(input logic [7:0] len, input int i);
        return 8'(int'(len) * 7 + i * 29 + 3);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e1[3];
        logic [7:0] e_data[$];
        logic       e_last[$];
        int e_ok, e_chk, e_len, sum, len, kind, n, bad;
        logic [7:0] b, chk;
        bit seen;

        tbl[0] = '{8'd3,    8'd0,   1, 0, 0, 3};
        tbl[1] = '{8'd1,    8'd0,   1, 0, 0, 1};
        tbl[2] = '{8'd16,   8'd0,   1, 0, 0, 16};
        tbl[3] = '{8'd0,    8'd0,   0, 0, 1, 0};
        tbl[4] = '{8'd17,   8'd0,   0, 0, 1, 0};
        tbl[5] = '{8'hA5,   8'd0,   0, 0, 1, 0};
        tbl[6] = '{8'd2,    8'd1,   0, 1, 0, 0};
        tbl[7] = '{8'd16,   8'h80,  0, 1, 0, 0};
        tbl[8] = '{8'hFF,   8'd0,   0, 0, 1, 0};

        // Asynchronous reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_data", o_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_pulses", {o_frame_ok, o_err_chk, o_err_len, o_err_timeout, o_overrun}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic frame, exact drain timing
        ready = 1'b1;
        e1[0] = 8'h11; e1[1] = 8'h22; e1[2] = 8'h33;
        snap();
        txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_txq(0);
        strobe(8'h69);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_valid", o_valid, 1);
            check("t1_data", o_data, e1[k]);
            check("t1_last", o_last, k == 2);
            check("t1_frame_ok", o_frame_ok, k == 0);
        end
        @(negedge clk);
        check("t1_busy_after", o_busy, 0);
        check("t1_valid_after", o_valid, 0);
        tick();
        check("t1_ok_count", n_ok - s_ok, 1);

        // Garbage, bad checksum, then a frame whose payload is the sync value
        snap();
        txq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_txq(1);
        idle(2);
        check("t2_err_chk", n_chk - s_chk, 1);
        check("t2_no_valid", n_valid - s_valid, 0);
        check("t2_no_other", (n_ok - s_ok) + (n_len - s_len), 0);
        check("t2_idle", o_busy, 0);
        txq = '{8'hA5, 8'h01, 8'hA5, 8'hA6};
        send_txq(0);
        wait_idle(50);
        tick();
        check("t2_nbytes", got_data.size() - s_got, 1);
        if (got_data.size() > s_got) begin
            check("t2_data", got_data[s_got], 8'hA5);
            check("t2_last", got_last[s_got], 1);
        end

        // Vector table of frame shapes
        foreach (tbl[v]) begin
            snap();
            txq.push_back(8'hA5);
            txq.push_back(tbl[v].len);
            if (tbl[v].bad_len == 0) begin
                sum = int'(tbl[v].len);
                for (int i = 0; i < int'(tbl[v].len); i++) begin
                    txq.push_back(pbyte(tbl[v].len, i));
                    sum += int'(pbyte(tbl[v].len, i));
                end
                txq.push_back(8'(sum + int'(tbl[v].chk_add)));
            end
            send_txq(1);
            wait_idle(100);
            idle(2);
            check($sformatf("tbl%0d_ok", v), n_ok - s_ok, tbl[v].ok);
            check($sformatf("tbl%0d_err_chk", v), n_chk - s_chk, tbl[v].bad_chk);
            check($sformatf("tbl%0d_err_len", v), n_len - s_len, tbl[v].bad_len);
            check($sformatf("tbl%0d_nbytes", v), got_data.size() - s_got, tbl[v].nbytes);
            bad = 0;
            for (int j = 0; j < tbl[v].nbytes && s_got + j < got_data.size(); j++) begin
                if (got_data[s_got + j] !== pbyte(tbl[v].len, j)) bad++;
                if (got_last[s_got + j] !== (j == tbl[v].nbytes - 1)) bad++;
            end
            check($sformatf("tbl%0d_payload", v), bad, 0);
        end

        // Timeout lands TIMEOUT-1 cycles after the last strobe
        snap();
        txq = '{8'hA5, 8'h02, 8'h10};
        send_txq(0);
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= int'(TIMEOUT) + 10 && !seen; i++) begin
            @(negedge clk);
            if (o_err_timeout) begin
                seen = 1'b1;
                n = i;
            end
        end
        check("to_cycle", n, TIMEOUT - 1);
        @(negedge clk);
        check("to_width", o_err_timeout, 0);
        check("to_idle", o_busy, 0);
        tick();
        txq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        send_txq(0);
        wait_idle(50);
        tick();
        check("to_recover_ok", n_ok - s_ok, 1);
        check("to_recover_nbytes", got_data.size() - s_got, 2);

        // Byte arriving on the terminal-count cycle wins over the timeout
        snap();
        txq = '{8'hA5, 8'h02};
        send_txq(0);
        idle(TIMEOUT - 3);
        txq = '{8'h10, 8'h20, 8'h32};
        send_txq(0);
        wait_idle(50);
        tick();
        check("tc_no_timeout", n_to - s_to, 0);
        check("tc_frame_ok", n_ok - s_ok, 1);

        // Back-pressure and overrun during drain
        snap();
        ready = 1'b0;
        txq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send_txq(0);
        strobe(8'h0E);
        @(negedge clk);
        check("st_valid", o_valid, 1);
        check("st_data0", o_data, 8'h01);
        tick();
        strobe(8'h77);
        @(negedge clk);
        check("st_overrun", o_overrun, 1);
        check("st_data_held", o_data, 8'h01);
        @(negedge clk);
        check("st_overrun_width", o_overrun, 0);
        check("st_last_held", o_last, 0);
        idle(2);
        check("st_data_still", o_data, 8'h01);
        ready = 1'b1;
        wait_idle(50);
        tick();
        check("st_ovr_count", n_ovr - s_ovr, 1);
        check("st_nbytes", got_data.size() - s_got, 4);
        bad = 0;
        for (int j = 0; j < 4 && s_got + j < got_data.size(); j++) begin
            if (got_data[s_got + j] !== 8'(j + 1)) bad++;
            if (got_last[s_got + j] !== (j == 3)) bad++;
        end
        check("st_payload", bad, 0);

        // Reset mid-payload
        snap();
        txq = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_txq(0);
        check("rs_busy_before", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_busy", o_busy, 0);
        check("rs_valid_data", {o_valid, o_last, o_data}, 0);
        idle(2);
        rst_n = 1'b1;
        tick();
        txq = '{8'h03, 8'h04, 8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
        send_txq(0);
        wait_idle(50);
        tick();
        check("rs_no_errors", (n_chk - s_chk) + (n_len - s_len) + (n_to - s_to), 0);
        check("rs_nbytes", got_data.size() - s_got, 2);
        if (got_data.size() >= s_got + 2) begin
            check("rs_data", {got_data[s_got], got_data[s_got + 1]}, 16'hAABB);
        end

        // Randomized frames against a frame-level model
        snap();
        e_ok = 0; e_chk = 0; e_len = 0;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 9) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom_range(0, 255));
                    txq.push_back(b == 8'hA5 ? 8'h5A : b);
                end
                send_txq(3);
            end else if (kind == 8) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                txq = '{8'hA5, 8'(len)};
                e_len++;
                send_txq(3);
            end else begin
                len = $urandom_range(1, MAX_LEN);
                txq = '{8'hA5, 8'(len)};
                sum = len;
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(0, 255));
                    txq.push_back(b);
                    sum += int'(b);
                    if (kind < 6) begin
                        e_data.push_back(b);
                        e_last.push_back(i == len - 1);
                    end
                end
                chk = (kind < 6) ? 8'(sum) : 8'(sum + $urandom_range(1, 255));
                txq.push_back(chk);
                if (kind < 6) e_ok++;
                else e_chk++;
                send_txq(3);
                for (int i = 0; i < 500 && o_busy; i++) begin
                    ready = 1'($urandom_range(0, 1));
                    tick();
                end
                check("rnd_drain", o_busy, 0);
            end
        end
        ready = 1'b1;
        idle(3);
        check("rnd_ok", n_ok - s_ok, e_ok);
        check("rnd_err_chk", n_chk - s_chk, e_chk);
        check("rnd_err_len", n_len - s_len, e_len);
        check("rnd_no_timeout", n_to - s_to, 0);
        check("rnd_no_overrun", n_ovr - s_ovr, 0);
        check("rnd_nbytes", got_data.size() - s_got, e_data.size());
        bad = 0;
        for (int j = 0; j < e_data.size() && s_got + j < got_data.size(); j++) begin
            if (got_data[s_got + j] !== e_data[j]) bad++;
            if (got_last[s_got + j] !== e_last[j]) bad++;
        end
        check("rnd_payload", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
